// File: rtl/vedacao_pkg.sv
// -----------------------------------------------------------------------------
// vedacao_pkg
// Shared definitions for the multi-channel bottle-sealing controller:
//   - estado_canal_t : per-channel sealing FSM state encoding
//   - LARG_CONTAGEM  : width of the optional completed/failed seal counters
//                      (present only when VEDACAO_CONTADOR_EN is defined)
//   - indice_rr / proximo_indice : round-robin index arithmetic
// -----------------------------------------------------------------------------
package vedacao_pkg;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        SOLICITA = 2'd1,
        VEDANDO  = 2'd2,
        VEDADA   = 2'd3
    } estado_canal_t;

    localparam int LARG_CONTAGEM = 16;

    // Channel index reached by stepping 'passo' positions from 'base' on a ring of n.
    function automatic int indice_rr(input int base, input int passo, input int n);
        return (base + passo) % n;
    endfunction

    // Pointer value after a grant to channel 'idx'.
    function automatic int proximo_indice(input int idx, input int n);
        return indice_rr(idx, 1, n);
    endfunction

endpackage

// File: rtl/vedacao_canal.sv
// -----------------------------------------------------------------------------
// vedacao_canal
// One sealing head: FSM ESPERA -> SOLICITA -> VEDANDO -> VEDADA plus seal timer.
// Ports:
//   CLOCK, RESET  : clock, synchronous active-high reset
//   CHEIA         : bottle at this head is full
//   PRESENTE      : bottle positioned at this head
//   CONCEDIDO     : cork grant from the arbiter (combinational, this cycle)
//   SOLICITA      : head is requesting a cork (state SOLICITA with bottle present)
//   VEDADA        : head in VEDADA (Moore)
//   FALHA         : registered one-cycle pulse when the bottle left during VEDANDO
//   CONCLUIU      : combinational, high in the cycle VEDANDO -> VEDADA is taken
// -----------------------------------------------------------------------------
module vedacao_canal
    import vedacao_pkg::*;
#(
    parameter int CICLOS_VEDACAO = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic CHEIA,
    input  logic PRESENTE,
    input  logic CONCEDIDO,
    output logic SOLICITA,
    output logic VEDADA,
    output logic FALHA,
    output logic CONCLUIU
);

    localparam int LARG_TEMPO = (CICLOS_VEDACAO > 1) ? $clog2(CICLOS_VEDACAO) : 1;
    localparam logic [LARG_TEMPO-1:0] TEMPO_CARGA = LARG_TEMPO'(CICLOS_VEDACAO - 1);

    estado_canal_t         estado_q, estado_d;
    logic [LARG_TEMPO-1:0] tempo_q, tempo_d;
    logic                  falha_q, falha_d;
    logic                  concluiu;

    always_comb begin
        estado_d = estado_q;
        tempo_d  = tempo_q;
        falha_d  = 1'b0;
        concluiu = 1'b0;
        case (estado_q)
            vedacao_pkg::ESPERA: begin
                if (CHEIA && PRESENTE) estado_d = vedacao_pkg::SOLICITA;
            end
            vedacao_pkg::SOLICITA: begin
                if (!PRESENTE) begin
                    estado_d = vedacao_pkg::ESPERA;
                end else if (CONCEDIDO) begin
                    estado_d = vedacao_pkg::VEDANDO;
                    tempo_d  = TEMPO_CARGA;
                end
            end
            vedacao_pkg::VEDANDO: begin
                // Bottle removal beats timer expiry: a seal is only good if the
                // bottle stayed for the full duration.
                if (!PRESENTE) begin
                    estado_d = vedacao_pkg::ESPERA;
                    falha_d  = 1'b1;
                end else if (tempo_q == '0) begin
                    estado_d = vedacao_pkg::VEDADA;
                    concluiu = 1'b1;
                end else begin
                    tempo_d = tempo_q - 1'b1;
                end
            end
            vedacao_pkg::VEDADA: begin
                if (!PRESENTE) estado_d = vedacao_pkg::ESPERA;
            end
            default: estado_d = vedacao_pkg::ESPERA;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            estado_q <= vedacao_pkg::ESPERA;
            falha_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            falha_q  <= falha_d;
        end
    end

    // Timer is always loaded on entry to VEDANDO, so it needs no reset.
    always_ff @(posedge CLOCK) begin
        tempo_q <= tempo_d;
    end

    // A head whose bottle is leaving is not offered to the arbiter, so a cork is
    // never granted to a bottle that is about to disappear.
    assign SOLICITA = (estado_q == vedacao_pkg::SOLICITA) && PRESENTE;
    assign VEDADA   = (estado_q == vedacao_pkg::VEDADA);
    assign FALHA    = falha_q;
    assign CONCLUIU = concluiu;

endmodule

// File: rtl/vedacao_multicanal.sv
// -----------------------------------------------------------------------------
// vedacao_multicanal
// N-channel bottle-sealing controller with shared cork stock and round-robin
// cork arbiter.
// Ports:
//   CLOCK, RESET        : clock, synchronous active-high reset
//   GARRAFA_CHEIA[i]    : bottle at head i is full
//   GARRAFA_PRESENTE[i] : bottle positioned at head i
//   REABASTECE          : one-cycle refill strobe, adds QTD_REABASTECE corks
//   GARRAFA_VEDADA[i]   : head i has a sealed bottle
//   FALHA_VEDACAO[i]    : one-cycle pulse, bottle left head i mid-seal
//   DECREMENTA_ROLHA    : one-cycle pulse per cork grant
//   CANAL_CONCEDIDO     : granted head index, valid with DECREMENTA_ROLHA
//   ESTOQUE_ROLHAS      : current cork stock
//   ESTOQUE_BAIXO       : stock <= LIMIAR_BAIXO (registered)
//   ESTOQUE_VAZIO       : stock == 0 (registered)
// Optional (macro VEDACAO_CONTADOR_EN):
//   CONTAGEM_VEDADAS    : wrapping count of completed seals
//   CONTAGEM_FALHAS     : wrapping count of FALHA_VEDACAO pulses
// -----------------------------------------------------------------------------
module vedacao_multicanal
    import vedacao_pkg::*;
#(
    parameter int N_CANAIS        = 4,
    parameter int LARG_ESTOQUE    = 8,
    parameter int ESTOQUE_INICIAL = 100,
    parameter int CICLOS_VEDACAO  = 4,
    parameter int LIMIAR_BAIXO    = 10,
    localparam int LARG_IDX       = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic [N_CANAIS-1:0]     GARRAFA_CHEIA,
    input  logic [N_CANAIS-1:0]     GARRAFA_PRESENTE,
    input  logic                    REABASTECE,
    input  logic [LARG_ESTOQUE-1:0] QTD_REABASTECE,
    output logic [N_CANAIS-1:0]     GARRAFA_VEDADA,
    output logic [N_CANAIS-1:0]     FALHA_VEDACAO,
    output logic                    DECREMENTA_ROLHA,
    output logic [LARG_IDX-1:0]     CANAL_CONCEDIDO,
    output logic [LARG_ESTOQUE-1:0] ESTOQUE_ROLHAS,
    output logic                    ESTOQUE_BAIXO,
    output logic                    ESTOQUE_VAZIO
`ifdef VEDACAO_CONTADOR_EN
    ,
    output logic [LARG_CONTAGEM-1:0] CONTAGEM_VEDADAS,
    output logic [LARG_CONTAGEM-1:0] CONTAGEM_FALHAS
`endif
);

    localparam logic [LARG_ESTOQUE-1:0] INICIAL_L = LARG_ESTOQUE'(ESTOQUE_INICIAL);
    localparam logic [LARG_ESTOQUE-1:0] LIMIAR_L  = LARG_ESTOQUE'(LIMIAR_BAIXO);

    function automatic logic [LARG_ESTOQUE-1:0] satura(input logic [LARG_ESTOQUE:0] v);
        return v[LARG_ESTOQUE] ? {LARG_ESTOQUE{1'b1}} : v[LARG_ESTOQUE-1:0];
    endfunction

    logic [N_CANAIS-1:0] solicita, vedada, falha, concluiu, concedido_vec;

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        vedacao_canal #(
            .CICLOS_VEDACAO(CICLOS_VEDACAO)
        ) u_canal (
            .CLOCK    (CLOCK),
            .RESET    (RESET),
            .CHEIA    (GARRAFA_CHEIA[i]),
            .PRESENTE (GARRAFA_PRESENTE[i]),
            .CONCEDIDO(concedido_vec[i]),
            .SOLICITA (solicita[i]),
            .VEDADA   (vedada[i]),
            .FALHA    (falha[i]),
            .CONCLUIU (concluiu[i])
        );
    end

    logic [LARG_IDX-1:0]     ptr_q, ptr_d;
    logic [LARG_IDX-1:0]     cand, concede_idx;
    logic                    concede_vld;
    logic [LARG_ESTOQUE-1:0] estoque_q, estoque_d;
    logic [LARG_ESTOQUE:0]   soma;
    logic                    dec_q, dec_d;
    logic [LARG_IDX-1:0]     canal_q, canal_d;
    logic                    baixo_q, baixo_d, vazio_q, vazio_d;

    // Arbiter: first requesting head found walking the ring from ptr_q.
    always_comb begin
        concede_vld   = 1'b0;
        concede_idx   = '0;
        cand          = '0;
        concedido_vec = '0;
        if (estoque_q != '0) begin
            for (int k = 0; k < N_CANAIS; k++) begin
                cand = LARG_IDX'(indice_rr(int'(ptr_q), k, N_CANAIS));
                if (!concede_vld && solicita[cand]) begin
                    concede_vld = 1'b1;
                    concede_idx = cand;
                end
            end
        end
        if (concede_vld) concedido_vec[concede_idx] = 1'b1;
    end

    // Stock update: one extra bit holds refill overflow before saturation.
    always_comb begin
        ptr_d   = ptr_q;
        canal_d = canal_q;
        dec_d   = concede_vld;
        if (concede_vld) begin
            ptr_d   = LARG_IDX'(proximo_indice(int'(concede_idx), N_CANAIS));
            canal_d = concede_idx;
        end
        soma = {1'b0, estoque_q}
             - {{LARG_ESTOQUE{1'b0}}, concede_vld}
             + (REABASTECE ? {1'b0, QTD_REABASTECE} : {(LARG_ESTOQUE+1){1'b0}});
        estoque_d = satura(soma);
        baixo_d   = (estoque_d <= LIMIAR_L);
        vazio_d   = (estoque_d == '0);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ptr_q     <= '0;
            canal_q   <= '0;
            dec_q     <= 1'b0;
            estoque_q <= INICIAL_L;
            baixo_q   <= (INICIAL_L <= LIMIAR_L);
            vazio_q   <= (INICIAL_L == '0);
        end else begin
            ptr_q     <= ptr_d;
            canal_q   <= canal_d;
            dec_q     <= dec_d;
            estoque_q <= estoque_d;
            baixo_q   <= baixo_d;
            vazio_q   <= vazio_d;
        end
    end

    assign GARRAFA_VEDADA   = vedada;
    assign FALHA_VEDACAO    = falha;
    assign DECREMENTA_ROLHA = dec_q;
    assign CANAL_CONCEDIDO  = canal_q;
    assign ESTOQUE_ROLHAS   = estoque_q;
    assign ESTOQUE_BAIXO    = baixo_q;
    assign ESTOQUE_VAZIO    = vazio_q;

`ifdef VEDACAO_CONTADOR_EN
    logic [LARG_CONTAGEM-1:0] cont_ved_q, cont_ved_d, cont_fal_q, cont_fal_d;

    // Completions are counted at the transition edge; failures are counted
    // from the registered pulse, so each visible FALHA_VEDACAO bit counts once.
    always_comb begin
        cont_ved_d = cont_ved_q;
        cont_fal_d = cont_fal_q;
        for (int i = 0; i < N_CANAIS; i++) begin
            cont_ved_d = cont_ved_d + LARG_CONTAGEM'(concluiu[i]);
            cont_fal_d = cont_fal_d + LARG_CONTAGEM'(falha[i]);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cont_ved_q <= '0;
            cont_fal_q <= '0;
        end else begin
            cont_ved_q <= cont_ved_d;
            cont_fal_q <= cont_fal_d;
        end
    end

    assign CONTAGEM_VEDADAS = cont_ved_q;
    assign CONTAGEM_FALHAS  = cont_fal_q;
`else
    logic unused_concluiu;
    assign unused_concluiu = ^concluiu;
`endif

endmodule

// File: tb/tb_vedacao_multicanal.sv
// -----------------------------------------------------------------------------
// tb_vedacao_multicanal
// Directed bench for vedacao_multicanal. Instance dut_a uses default
// parameters (stock 100); instance dut_b starts with stock 1 for the
// empty-stock, saturation and low-threshold scenarios.
// Counter outputs are exercised when VEDACAO_CONTADOR_EN is defined.
// -----------------------------------------------------------------------------
module tb_vedacao_multicanal;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, reab_a, dec_a, baixo_a, vazio_a;
    logic [3:0] cheia_a, pres_a, vedada_a, falha_a;
    logic [1:0] canal_a;
    logic [7:0] qtd_a, est_a;

    logic       rst_b, reab_b, dec_b, baixo_b, vazio_b;
    logic [3:0] cheia_b, pres_b, vedada_b, falha_b;
    logic [1:0] canal_b;
    logic [7:0] qtd_b, est_b;

`ifdef VEDACAO_CONTADOR_EN
    logic [15:0] cved_a, cfal_a, cved_b, cfal_b;
`endif

    vedacao_multicanal dut_a (
        .CLOCK(clk), .RESET(rst_a),
        .GARRAFA_CHEIA(cheia_a), .GARRAFA_PRESENTE(pres_a),
        .REABASTECE(reab_a), .QTD_REABASTECE(qtd_a),
        .GARRAFA_VEDADA(vedada_a), .FALHA_VEDACAO(falha_a),
        .DECREMENTA_ROLHA(dec_a), .CANAL_CONCEDIDO(canal_a),
        .ESTOQUE_ROLHAS(est_a), .ESTOQUE_BAIXO(baixo_a), .ESTOQUE_VAZIO(vazio_a)
`ifdef VEDACAO_CONTADOR_EN
        , .CONTAGEM_VEDADAS(cved_a), .CONTAGEM_FALHAS(cfal_a)
`endif
    );

    vedacao_multicanal #(.ESTOQUE_INICIAL(1)) dut_b (
        .CLOCK(clk), .RESET(rst_b),
        .GARRAFA_CHEIA(cheia_b), .GARRAFA_PRESENTE(pres_b),
        .REABASTECE(reab_b), .QTD_REABASTECE(qtd_b),
        .GARRAFA_VEDADA(vedada_b), .FALHA_VEDACAO(falha_b),
        .DECREMENTA_ROLHA(dec_b), .CANAL_CONCEDIDO(canal_b),
        .ESTOQUE_ROLHAS(est_b), .ESTOQUE_BAIXO(baixo_b), .ESTOQUE_VAZIO(vazio_b)
`ifdef VEDACAO_CONTADOR_EN
        , .CONTAGEM_VEDADAS(cved_b), .CONTAGEM_FALHAS(cfal_b)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; cheia_a = '0; pres_a = '0; reab_a = 1'b0; qtd_a = '0;
        rst_b = 1'b1; cheia_b = '0; pres_b = '0; reab_b = 1'b0; qtd_b = '0;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset state
        chk("rst_estoque", 32'(est_a), 32'd100);
        chk("rst_baixo", 32'(baixo_a), 32'd0);
        chk("rst_vazio", 32'(vazio_a), 32'd0);
        chk("rst_dec", 32'(dec_a), 32'd0);
        chk("rst_vedada", 32'(vedada_a), 32'd0);
        chk("rst_falha", 32'(falha_a), 32'd0);
        chk("rst_b_estoque", 32'(est_b), 32'd1);
        chk("rst_b_baixo", 32'(baixo_b), 32'd1);
        chk("rst_b_vazio", 32'(vazio_b), 32'd0);

        // Single channel seal on head 0
        cheia_a = 4'b0001; pres_a = 4'b0001;
        tick();
        chk("t1_dec_pre", 32'(dec_a), 32'd0);
        tick();
        chk("t1_dec", 32'(dec_a), 32'd1);
        chk("t1_canal", 32'(canal_a), 32'd0);
        chk("t1_estoque", 32'(est_a), 32'd99);
        tick();
        chk("t1_dec_once", 32'(dec_a), 32'd0);
        tick();
        tick();
        chk("t1_vedada_early", 32'(vedada_a), 32'd0);
        tick();
        chk("t1_vedada", 32'(vedada_a), 32'b0001);
        chk("t1_estoque_hold", 32'(est_a), 32'd99);
`ifdef VEDACAO_CONTADOR_EN
        chk("t1_contagem", 32'(cved_a), 32'd1);
`endif
        cheia_a = '0; pres_a = '0;
        tick();
        chk("t1_vedada_clr", 32'(vedada_a), 32'd0);

        // All four heads request together
        reset_a();
        cheia_a = 4'b1111; pres_a = 4'b1111;
        tick();
        chk("t2_dec_pre", 32'(dec_a), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_dec", 32'(dec_a), 32'd1);
            chk("t2_canal", 32'(canal_a), 32'(k));
            chk("t2_estoque", 32'(est_a), 32'(99 - k));
        end
        tick();
        chk("t2_dec_end", 32'(dec_a), 32'd0);
        chk("t2_estoque_end", 32'(est_a), 32'd96);
        chk("t2_vedada0", 32'(vedada_a), 32'b0001);
        tick();
        chk("t2_vedada01", 32'(vedada_a), 32'b0011);
        cheia_a = '0; pres_a = '0;
        tick();
        chk("t2_vedada_clr", 32'(vedada_a), 32'd0);

        // Bottle leaves head 2 mid-seal
        reset_a();
        cheia_a = 4'b0100; pres_a = 4'b0100;
        tick();
        tick();
        chk("t4_dec", 32'(dec_a), 32'd1);
        chk("t4_canal", 32'(canal_a), 32'd2);
        chk("t4_estoque", 32'(est_a), 32'd99);
        tick();
        cheia_a = '0; pres_a = '0;
        tick();
        chk("t4_falha", 32'(falha_a), 32'b0100);
        chk("t4_vedada", 32'(vedada_a), 32'd0);
        chk("t4_estoque_kept", 32'(est_a), 32'd99);
        tick();
        chk("t4_falha_pulse", 32'(falha_a), 32'd0);
`ifdef VEDACAO_CONTADOR_EN
        chk("t4_cfal", 32'(cfal_a), 32'd1);
`endif
        tick();
        tick();
        chk("t4_vedada_never", 32'(vedada_a), 32'd0);
        chk("t4_estoque_final", 32'(est_a), 32'd99);

        // Reset during VEDANDO on head 1, with the bottle leaving at the same edge
        reset_a();
        cheia_a = 4'b0010; pres_a = 4'b0010;
        tick();
        tick();
        chk("t6_dec", 32'(dec_a), 32'd1);
        chk("t6_canal", 32'(canal_a), 32'd1);
        tick();
        rst_a = 1'b1; cheia_a = '0; pres_a = '0;
        tick();
        chk("t6_falha", 32'(falha_a), 32'd0);
        chk("t6_vedada", 32'(vedada_a), 32'd0);
        chk("t6_dec_rst", 32'(dec_a), 32'd0);
        chk("t6_canal_rst", 32'(canal_a), 32'd0);
        chk("t6_estoque", 32'(est_a), 32'd100);
        chk("t6_baixo", 32'(baixo_a), 32'd0);
        chk("t6_vazio", 32'(vazio_a), 32'd0);
`ifdef VEDACAO_CONTADOR_EN
        chk("t6_cved", 32'(cved_a), 32'd0);
        chk("t6_cfal", 32'(cfal_a), 32'd0);
`endif
        rst_a = 1'b0;
        tick();
        chk("t6_falha_after", 32'(falha_a), 32'd0);
        chk("t6_estoque_after", 32'(est_a), 32'd100);

        // Stock of 1: head 0 takes the last cork, head 1 stalls until refill
        cheia_b = 4'b0011; pres_b = 4'b0011;
        tick();
        chk("t3_dec_pre", 32'(dec_b), 32'd0);
        tick();
        chk("t3_dec0", 32'(dec_b), 32'd1);
        chk("t3_canal0", 32'(canal_b), 32'd0);
        chk("t3_estoque0", 32'(est_b), 32'd0);
        chk("t3_vazio", 32'(vazio_b), 32'd1);
        tick();
        chk("t3_stall", 32'(dec_b), 32'd0);
        tick();
        chk("t3_stall2", 32'(dec_b), 32'd0);
        reab_b = 1'b1; qtd_b = 8'd5;
        tick();
        reab_b = 1'b0; qtd_b = '0;
        chk("t3_refill", 32'(est_b), 32'd5);
        chk("t3_vazio_clr", 32'(vazio_b), 32'd0);
        chk("t3_dec_refill", 32'(dec_b), 32'd0);
        tick();
        chk("t3_dec1", 32'(dec_b), 32'd1);
        chk("t3_canal1", 32'(canal_b), 32'd1);
        chk("t3_estoque1", 32'(est_b), 32'd4);
        tick();
        chk("t3_estoque_end", 32'(est_b), 32'd4);
        chk("t3_dec_end", 32'(dec_b), 32'd0);

        // Saturation: stock 250, grant and refill of 20 on the same edge
        cheia_b = '0; pres_b = '0;
        reset_b();
        reab_b = 1'b1; qtd_b = 8'd249; cheia_b = 4'b0100; pres_b = 4'b0100;
        tick();
        chk("t5_estoque250", 32'(est_b), 32'd250);
        qtd_b = 8'd20;
        tick();
        reab_b = 1'b0; qtd_b = '0;
        chk("t5_dec", 32'(dec_b), 32'd1);
        chk("t5_canal", 32'(canal_b), 32'd2);
        chk("t5_saturado", 32'(est_b), 32'd255);
        tick();
        chk("t5_saturado_hold", 32'(est_b), 32'd255);

        // Low-stock threshold: 11 -> 10 on a grant
        cheia_b = '0; pres_b = '0;
        reset_b();
        reab_b = 1'b1; qtd_b = 8'd10; cheia_b = 4'b1000; pres_b = 4'b1000;
        tick();
        reab_b = 1'b0; qtd_b = '0;
        chk("t5_estoque11", 32'(est_b), 32'd11);
        chk("t5_baixo_off", 32'(baixo_b), 32'd0);
        tick();
        chk("t5_estoque10", 32'(est_b), 32'd10);
        chk("t5_baixo_on", 32'(baixo_b), 32'd1);
        chk("t5_canal3", 32'(canal_b), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vedacao_multicanal.md
Name: vedacao_multicanal

Overview:
Parametrised N-channel bottle-sealing controller with a shared cork-stock counter.
- Each channel runs its own sealing FSM with a timed seal phase.
- A round-robin arbiter grants at most one cork per cycle.
- The internal stock counter handles refill, low-stock and empty flags.
- Sits after the filling stage; feeds line status and inventory to the supervisor.

Parameters:
N_CANAIS, 4, number of sealing heads (1..8)
LARG_ESTOQUE, 8, width of cork-stock counter
ESTOQUE_INICIAL, 100, stock value loaded on reset (must be ≤ 2^LARG_ESTOQUE-1)
CICLOS_VEDACAO, 4, clock cycles a channel stays in VEDANDO (≥1)
LIMIAR_BAIXO, 10, ESTOQUE_BAIXO asserted when stock ≤ this value

Ports:
CLOCK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
GARRAFA_CHEIA  in  N_CANAIS  bottle at channel i is full
GARRAFA_PRESENTE  in  N_CANAIS  bottle positioned at channel i
REABASTECE  in  1  one-cycle refill strobe
QTD_REABASTECE  in  LARG_ESTOQUE  corks added on REABASTECE
GARRAFA_VEDADA  out  N_CANAIS  channel i in VEDADA (Moore)
FALHA_VEDACAO  out  N_CANAIS  one-cycle pulse when a bottle leaves during VEDANDO
DECREMENTA_ROLHA  out  1  one-cycle pulse on each cork grant
CANAL_CONCEDIDO  out  $clog2(N_CANAIS) (min 1)  index of granted channel, valid with DECREMENTA_ROLHA
ESTOQUE_ROLHAS  out  LARG_ESTOQUE  current stock
ESTOQUE_BAIXO  out  1  stock ≤ LIMIAR_BAIXO
ESTOQUE_VAZIO  out  1  stock == 0

Behaviour:
- Reset (synchronous, RESET high at a CLOCK edge):
  - All channels go to ESPERA.
  - Arbiter pointer = 0.
  - Stock = ESTOQUE_INICIAL.
  - All pulses are 0.
  - Flags reflect ESTOQUE_INICIAL from the first cycle after reset.
  - Reset mid-seal aborts the seal with no FALHA pulse and no stock change.
- Channel FSM, states ESPERA, SOLICITA, VEDANDO, VEDADA:
  - ESPERA -> SOLICITA when CHEIA[i] & PRESENTE[i].
  - SOLICITA -> ESPERA if PRESENTE[i] drops; no pulse.
  - SOLICITA -> VEDANDO on grant. Load timer = CICLOS_VEDACAO-1.
  - VEDANDO: decrement the timer each cycle. At timer == 0 -> VEDADA.
  - VEDANDO with PRESENTE[i] low -> ESPERA. FALHA_VEDACAO[i] pulses for 1 cycle. The cork is not returned to stock.
  - VEDADA -> ESPERA when PRESENTE[i] drops. GARRAFA_VEDADA[i] = (state == VEDADA).
- Arbiter:
  - Candidates are channels in SOLICITA.
  - Grant is issued only if stock > 0.
  - Selection is round-robin starting at the pointer. After a grant, the pointer = granted index + 1, modulo N_CANAIS.
  - Grant is combinational from registered state. The channel enters VEDANDO at the next edge, and DECREMENTA_ROLHA and CANAL_CONCEDIDO are registered at that same edge, so they are visible for exactly 1 cycle.
  - Stock is 0: no grant; requesting channels hold in SOLICITA.
- Stock arithmetic, evaluated per edge:
  - next = stock − grant + (REABASTECE ? QTD_REABASTECE : 0).
  - Compute in LARG_ESTOQUE+1 bits and saturate at 2^LARG_ESTOQUE−1.
  - Simultaneous grant and refill are both applied.
  - A grant never occurs at stock 0, so no underflow is possible.
  - A refill at stock 0 makes stock available for grants from the next cycle.
- Latency:
  - Request to grant: ≥1 cycle.
  - Grant to GARRAFA_VEDADA: CICLOS_VEDACAO cycles.
  - Flags are registered and update in the same cycle as ESTOQUE_ROLHAS.

Optional Feature:
Macro VEDACAO_CONTADOR_EN.
- Defined: adds output CONTAGEM_VEDADAS, 16 bits, reset 0.
  - Increments on each VEDANDO->VEDADA transition, summed over channels that complete in the same cycle.
  - Wraps at 2^16.
  - Also adds output CONTAGEM_FALHAS, 16 bits, same rules, counting FALHA_VEDACAO pulses.
- Undefined: neither port exists; the rest of the behaviour is identical.

Decomposition:
- Package vedacao_pkg:
  - channel state encoding as an enumerated type (ESPERA=0, SOLICITA=1, VEDANDO=2, VEDADA=3).
  - counter width constant for CONTAGEM_VEDADAS (16).
  - helper function for the round-robin next-index calculation.
- Sub-module vedacao_canal:
  - One channel FSM plus its seal timer; instantiated N_CANAIS times.
  - Inputs: CLOCK, RESET, CHEIA, PRESENTE, CONCEDIDO.
  - Outputs: SOLICITA, VEDADA, FALHA, CONCLUIU.
- The arbiter and the stock counter stay in the top module.

Test Plan:
- Reset, then channel 0 full+present held, CICLOS_VEDACAO=4 -> exactly one DECREMENTA_ROLHA with CANAL_CONCEDIDO=0; stock 100->99; GARRAFA_VEDADA[0]=1 four cycles after the grant; it clears one cycle after PRESENTE[0] drops.
- All 4 channels request in the same cycle -> grants to channels 0, 1, 2, 3 on consecutive cycles; stock 100->96; no double grant in any cycle.
- ESTOQUE_INICIAL=1, channels 0 and 1 request -> channel 0 granted; ESTOQUE_VAZIO=1; channel 1 stalls in SOLICITA; REABASTECE with QTD=5 -> channel 1 granted next cycle; stock ends at 4.
- PRESENTE[2] dropped 2 cycles into VEDANDO -> FALHA_VEDACAO[2] is a single 1-cycle pulse; stock is not restored; GARRAFA_VEDADA[2] never asserts.
- Stock 250 (LARG_ESTOQUE=8), REABASTECE with QTD=20 in the same cycle as a grant -> stock saturates at 255; with stock 11 and LIMIAR_BAIXO=10, a grant -> ESTOQUE_BAIXO rises in the cycle stock becomes 10.
- RESET asserted mid-VEDANDO -> next cycle all outputs at reset values; stock = ESTOQUE_INICIAL; no FALHA pulse. With VEDACAO_CONTADOR_EN defined, CONTAGEM_VEDADAS returns to 0.
